// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch (IF) and load/store (LS).
// One outstanding transaction, LS priority with an IF anti-starvation limit, response timeout.
module mem_port_arbiter #(
   parameter int unsigned MAX_LS_STREAK  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [3:0]  ls_mask,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_mask,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        stall
);
   localparam int unsigned STREAK_W = $clog2(MAX_LS_STREAK + 1);
   localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef enum logic {OWN_IF, OWN_LS} owner_t;

   state_t              r_state, w_state_nxt;
   owner_t              r_owner, w_owner_nxt;
   logic [STREAK_W-1:0] r_streak, w_streak_nxt;
   logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;

   logic w_resp, w_timeout, w_issue_win, w_sel_ls, w_sel_if, w_accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_owner  <= OWN_IF;
         r_streak <= '0;
         r_tmo    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_streak <= w_streak_nxt;
         r_tmo    <= w_tmo_nxt;
      end
   end

   // Issue window and arbitration: LS wins unless its streak has hit the limit with IF waiting.
   always_comb begin
      w_resp      = (r_state == S_WAIT) && mem_rvalid;
      w_timeout   = (r_state == S_WAIT) && !mem_rvalid && (r_tmo == TMO_LAST);
      w_issue_win = (r_state == S_IDLE) || w_resp;
      w_sel_ls    = ls_req && !(if_req && (r_streak == STREAK_MAX));
      w_sel_if    = if_req && !w_sel_ls;
      w_accept    = rst_n && w_issue_win && (w_sel_ls || w_sel_if) && mem_gnt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_streak_nxt = r_streak;
      w_tmo_nxt    = r_tmo;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_resp)         w_state_nxt = w_accept ? S_WAIT : S_IDLE;
            else if (w_timeout) w_state_nxt = S_IDLE;
            else                w_tmo_nxt   = r_tmo + TMO_W'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_accept) begin
         w_owner_nxt = w_sel_ls ? OWN_LS : OWN_IF;
         w_tmo_nxt   = '0;
         if (w_sel_ls && if_req) begin
            if (r_streak != STREAK_MAX) w_streak_nxt = r_streak + STREAK_W'(1);
         end else begin
            w_streak_nxt = '0;
         end
      end
   end

   // Everything is held at zero while reset is asserted.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_mask  = '0;
      if_gnt    = 1'b0;
      ls_gnt    = 1'b0;
      if_rvalid = 1'b0;
      ls_rvalid = 1'b0;
      if_err    = 1'b0;
      ls_err    = 1'b0;
      if_rdata  = '0;
      ls_rdata  = '0;
      stall     = 1'b0;
      if (rst_n) begin
         mem_req = w_issue_win && (if_req || ls_req);
         if (w_sel_ls) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_mask  = ls_mask;
         end else if (w_sel_if) begin
            mem_addr  = if_addr;
            mem_mask  = 4'b1111;
         end
         ls_gnt = mem_req && w_sel_ls && mem_gnt;
         if_gnt = mem_req && w_sel_if && mem_gnt;
         if (r_owner == OWN_LS) begin
            ls_rvalid = w_resp || w_timeout;
            ls_err    = w_timeout;
            ls_rdata  = w_resp ? mem_rdata : '0;
         end else begin
            if_rvalid = w_resp || w_timeout;
            if_err    = w_timeout;
            if_rdata  = w_resp ? mem_rdata : '0;
         end
         stall = (ls_req && !ls_gnt) ||
                 ((r_state == S_WAIT) && (r_owner == OWN_LS) && !mem_rvalid);
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random requesters and memory driven from a cycle-level reference
// model; responses are checked through a scoreboard queue by an independent monitor.
module tb_mem_port_arbiter;
   localparam int unsigned MAX_STREAK = 4;
   localparam int unsigned TMO        = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_gnt, if_rvalid, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
   logic [31:0] ls_addr, ls_wdata, ls_rdata;
   logic [3:0]  ls_mask;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_mask;
   logic        stall;

   mem_port_arbiter #(.MAX_LS_STREAK(MAX_STREAK), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_mask(ls_mask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .ls_err(ls_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_mask(mem_mask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        owner;
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   resp_t sb_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   // Stimulus knobs (percentages) and latency mode: 0 random, 1 one cycle, 2 never, 3 two cycles
   int   p_if, p_ls, p_gnt, p_stray, lat_mode;
   logic rst_v;

   // Requester-side pending requests
   logic        if_pend, ls_pend, ls_w;
   logic [31:0] if_a, ls_a, ls_d;
   logic [3:0]  ls_m;

   // Reference model: one outstanding transaction with an age count, plus the LS streak
   logic        m_busy, m_owner, m_never;
   int          m_age, m_lat, m_streak;
   logic [31:0] m_rd;
   logic [31:0] mem_arr [logic [31:0]];

   // DUT observations from the latest cycle, for directed checks against constants
   logic        last_if_gnt, last_ls_gnt, last_if_rv, last_if_err, last_ls_rv;
   logic [31:0] last_ls_rd, last_mem_addr;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      return 32'h100 + 32'($urandom_range(15)) * 32'd4 + 32'($urandom_range(3));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic step();
      logic        m_resp, tmo, stray, win, sel_ls, e_req, e_ig, e_lg;
      logic        e_irv, e_lrv, e_ierr, e_lerr, e_stall, e_we;
      logic [31:0] e_addr, k;
      logic [3:0]  e_mask;
      logic [7:0]  e_ctl, a_ctl;
      resp_t       item;
      int          r;
      @(negedge clk);
      if (!if_pend && int'($urandom_range(99)) < p_if) begin
         if_pend = 1'b1;
         if_a    = rand_addr();
      end
      if (!ls_pend && int'($urandom_range(99)) < p_ls) begin
         ls_pend = 1'b1;
         ls_w    = 1'($urandom_range(1));
         ls_a    = rand_addr();
         ls_d    = $urandom;
         ls_m    = 4'($urandom);
      end
      m_resp = m_busy && !m_never && (m_age == m_lat - 1);
      tmo    = m_busy && !m_resp && (m_age == int'(TMO) - 1);
      stray  = !m_busy && (int'($urandom_range(99)) < p_stray);
      rst_n      = rst_v;
      if_req     = if_pend;
      if_addr    = if_a;
      ls_req     = ls_pend;
      ls_we      = ls_w;
      ls_addr    = ls_a;
      ls_wdata   = ls_d;
      ls_mask    = ls_m;
      mem_gnt    = int'($urandom_range(99)) < p_gnt;
      mem_rvalid = m_resp || stray;
      mem_rdata  = m_resp ? m_rd : $urandom;

      win     = !m_busy || m_resp;
      sel_ls  = ls_pend && !(if_pend && m_streak == int'(MAX_STREAK));
      e_req   = rst_v && win && (if_pend || ls_pend);
      e_lg    = e_req && sel_ls && mem_gnt;
      e_ig    = e_req && !sel_ls && mem_gnt;
      e_lrv   = rst_v && m_owner && (m_resp || tmo);
      e_irv   = rst_v && !m_owner && (m_resp || tmo);
      e_lerr  = e_lrv && tmo;
      e_ierr  = e_irv && tmo;
      e_stall = rst_v && ((ls_pend && !e_lg) || (m_busy && m_owner && !m_resp));
      e_we    = sel_ls ? ls_w : 1'b0;
      e_addr  = sel_ls ? ls_a : if_a;
      e_mask  = sel_ls ? ls_m : 4'hF;

      #1;
      e_ctl = {e_req, e_ig, e_lg, e_irv, e_lrv, e_ierr, e_lerr, e_stall};
      a_ctl = {mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err & if_rvalid,
               ls_err & ls_rvalid, stall};
      check("ctl{req,ig,lg,irv,lrv,ierr,lerr,stall}", 160'(a_ctl), 160'(e_ctl));
      if (!rst_v) begin
         check("reset_data", 160'({mem_we, mem_addr, mem_wdata, mem_mask, if_rdata, ls_rdata}),
               160'd0);
      end else if (e_req) begin
         check("mem_addr", 160'(mem_addr), 160'(e_addr));
         check("mem_we_mask", 160'({mem_we, mem_mask}), 160'({e_we, e_mask}));
         if (sel_ls && ls_w) check("mem_wdata", 160'(mem_wdata), 160'(ls_d));
      end
      last_if_gnt   = if_gnt;
      last_ls_gnt   = ls_gnt;
      last_if_rv    = if_rvalid;
      last_if_err   = if_err;
      last_ls_rv    = ls_rvalid;
      last_ls_rd    = ls_rdata;
      last_mem_addr = mem_addr;

      if (!rst_v) begin
         if (m_busy) sb_q.delete(sb_q.size() - 1);
         m_busy   = 1'b0;
         m_streak = 0;
         m_age    = 0;
      end else begin
         if (m_resp || tmo) m_busy = 1'b0;
         else if (m_busy)   m_age++;
         if (e_ig || e_lg) begin
            m_owner = e_lg;
            m_busy  = 1'b1;
            m_age   = 0;
            m_never = 1'b0;
            case (lat_mode)
               1: m_lat = 1;
               2: m_never = 1'b1;
               3: m_lat = 2;
               default: begin
                  r = int'($urandom_range(9));
                  m_lat   = (r <= 5) ? 1 : (r == 6) ? 2 : (r == 7) ? 3 : int'(TMO);
                  m_never = (r == 9);
               end
            endcase
            k = e_addr & ~32'h3;
            if (!mem_arr.exists(k)) mem_arr[k] = $urandom;
            if (e_lg && ls_w) begin
               m_rd       = $urandom;
               mem_arr[k] = merge(mem_arr[k], ls_d, ls_m);
            end else begin
               m_rd = mem_arr[k];
            end
            item.owner = e_lg;
            item.err   = m_never;
            item.rdata = m_never ? 32'd0 : m_rd;
            sb_q.push_back(item);
            if (e_lg) begin
               m_streak = if_pend ? ((m_streak < int'(MAX_STREAK)) ? m_streak + 1 : m_streak) : 0;
               ls_pend  = 1'b0;
            end else begin
               m_streak = 0;
               if_pend  = 1'b0;
            end
         end
      end
   endtask

   task automatic sb_pop(input logic own, input logic err, input logic [31:0] rd);
      resp_t e;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_unexpected: got rvalid owner=%0d err=%0d rdata=%0h expected none at %0t",
                  own, err, rd, $time);
         return;
      end
      e = sb_q.pop_front();
      check("sb_resp{owner,err,rdata}", 160'({own, err, rd}), 160'({e.owner, e.err, e.rdata}));
   endtask

   // Monitor: pops an expected response whenever the DUT presents one
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (if_rvalid) sb_pop(1'b0, if_err, if_rdata);
         if (ls_rvalid) sb_pop(1'b1, ls_err, ls_rdata);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic drain(input int n);
      p_if = 0; p_ls = 0; p_gnt = 100; lat_mode = 1;
      repeat (n) step();
   endtask

   initial begin
      logic [9:0] gseq;
      int         gn, idx;
      logic [31:0] rd;
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
      ls_wdata = '0; ls_mask = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if_pend = 1'b0; ls_pend = 1'b0; ls_w = 1'b0; if_a = '0; ls_a = '0; ls_d = '0; ls_m = '0;
      m_busy = 1'b0; m_owner = 1'b0; m_never = 1'b0; m_age = 0; m_lat = 1; m_streak = 0;
      m_rd = '0; p_stray = 10;

      // Reset with both requesters active, then contention from the first post-reset cycle
      rst_v = 1'b0; p_if = 100; p_ls = 100; p_gnt = 100; lat_mode = 1;
      repeat (3) step();
      rst_v = 1'b1;
      gseq = '0; gn = 0;
      repeat (12) begin
         step();
         if ((last_if_gnt || last_ls_gnt) && gn < 10) begin
            gseq[gn] = last_if_gnt;
            gn++;
         end
      end
      check("contention_grant_count", 160'(gn), 160'(10));
      check("contention_order_if_bits", 160'(gseq), 160'(10'h210));
      drain(10);

      // LS-only load with two-cycle memory latency
      mem_arr[32'h100] = 32'hDEADBEEF;
      ls_pend = 1'b1; ls_w = 1'b0; ls_a = 32'h100; ls_d = '0; ls_m = 4'hF;
      lat_mode = 3; idx = -1; rd = '0;
      for (int i = 1; i <= 5; i++) begin
         step();
         if (last_ls_rv && idx < 0) begin idx = i; rd = last_ls_rd; end
      end
      check("ls_only_resp_cycle", 160'(idx), 160'(3));
      check("ls_only_rdata", 160'(rd), 160'(32'hDEADBEEF));
      drain(5);

      // IF backpressure, then an IF read that never gets a response
      if_pend = 1'b1; if_a = 32'h40; p_gnt = 0;
      repeat (3) begin
         step();
         check("bp_if_gnt", 160'(last_if_gnt), 160'(0));
         check("bp_mem_addr", 160'(last_mem_addr), 160'(32'h40));
      end
      p_gnt = 100; lat_mode = 2;
      step();
      check("bp_grant_4th", 160'(last_if_gnt), 160'(1));
      idx = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (last_if_rv && idx < 0) begin
            idx = i;
            check("timeout_err", 160'(last_if_err), 160'(1));
         end
      end
      check("timeout_wait_cycle", 160'(idx), 160'(TMO));
      p_stray = 100;
      repeat (4) step();
      p_stray = 10;

      // Randomized traffic with periodically changing mix
      for (int blk = 0; blk < 15; blk++) begin
         p_if = int'($urandom_range(100)); p_ls = int'($urandom_range(100));
         p_gnt = int'($urandom_range(100, 30)); lat_mode = 0;
         repeat (200) step();
      end
      drain(20);

      // Reset while an LS load is outstanding
      ls_pend = 1'b1; ls_w = 1'b0; ls_a = 32'h300; ls_m = 4'hF;
      p_if = 0; p_ls = 0; p_gnt = 100; lat_mode = 2;
      repeat (3) step();
      rst_v = 1'b0; p_ls = 100;
      repeat (2) step();
      rst_v = 1'b1;
      step();
      check("post_reset_first_ls_gnt", 160'(last_ls_gnt), 160'(1));
      p_ls = 0; lat_mode = 1;
      drain(20);
      check("sb_empty_at_end", 160'(sb_q.size()), 160'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- The LS requester is the execute-stage load/store path that produces the address, byte mask and store data.
- One transaction is outstanding at a time, with back-to-back issue on response.
- Provides fixed LS priority with an anti-starvation limit for IF, a response timeout with error reporting, and a pipeline stall output.

Parameters:
- MAX_LS_STREAK, 4: consecutive LS grants allowed while if_req is pending; then IF is forced.
- TIMEOUT_CYCLES, 64: cycles waiting for mem_rvalid before the transaction is aborted with an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- if_req  in  1  IF read request; held stable until if_gnt
- if_addr  in  32  IF word address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF response valid (1-cycle pulse)
- if_rdata  out  32  IF read data
- if_err  out  1  IF response is a timeout error (qualified by if_rvalid)
- ls_req  in  1  LS request; held stable until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  32  LS address
- ls_wdata  in  32  LS store data (already lane-aligned)
- ls_mask  in  4  LS byte enables
- ls_gnt  out  1  LS request accepted
- ls_rvalid  out  1  LS completion (loads and stores)
- ls_rdata  out  32  LS load data (raw word)
- ls_err  out  1  LS timeout error (qualified by ls_rvalid)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_mask  out  4  memory byte enables (4'b1111 for IF)
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response/ack
- mem_rdata  in  32  memory read data
- stall  out  1  pipeline stall

Behaviour:
- FSM states:
  - IDLE: no outstanding transaction.
  - WAIT: one outstanding transaction; owner register holds IF or LS.
- Issue window: state == IDLE, or state == WAIT with mem_rvalid high this cycle (back-to-back).
- Outside the issue window: mem_req = 0.
- Arbitration inside the issue window:
  - If only one requester is active, it is selected.
  - If both are active: LS is selected unless streak_cnt == MAX_LS_STREAK, in which case IF is selected.
- Selected requester's fields drive mem_*. IF drives mem_we = 0 and mem_mask = 4'b1111.
- Grants: mem_req and the selected requester's gnt follow mem_gnt combinationally. The other requester's gnt = 0.
- Grant accepted (mem_req && mem_gnt):
  - state goes to WAIT, owner is set to the selected requester, timeout counter cleared.
  - streak_cnt increments on an LS grant while if_req = 1, saturating at MAX_LS_STREAK.
  - streak_cnt clears on any IF grant, or on an LS grant while if_req = 0.
- Not granted: the request is retried next cycle. Arbitration is re-evaluated, so a newly raised LS may displace a pending IF unless the streak limit forces IF.
- In WAIT with mem_rvalid high:
  - Owner's rvalid = 1, owner's rdata = mem_rdata, owner's err = 0 (all combinational).
  - Next state is WAIT if a new grant is accepted the same cycle, else IDLE.
- In WAIT without mem_rvalid: the timeout counter increments.
  - On reaching TIMEOUT_CYCLES-1: owner's rvalid = 1, err = 1, rdata = 0; state goes to IDLE.
  - No issue that cycle. A later stray mem_rvalid is ignored.
- mem_rvalid in IDLE is ignored: no rvalid output, no state change.
- stall = (ls_req && !ls_gnt) || (state == WAIT && owner == LS && !mem_rvalid). It is a cycle-exact pipeline hold.
- Reset (async assert, any state, including mid-transaction):
  - state = IDLE, streak_cnt = 0, timeout counter = 0.
  - While rst_n = 0: mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err and stall are forced to 0.
  - mem_addr, mem_wdata, mem_mask, mem_we, if_rdata and ls_rdata are forced to 0.
  - An aborted transaction produces no response.
  - The first issue is possible in the first cycle after deassertion.
- Widths: streak counter is $clog2(MAX_LS_STREAK+1) bits; timeout counter is $clog2(TIMEOUT_CYCLES) bits. No other arithmetic.

Test Plan:
- LS only: ls_req = 1, ls_we = 0, ls_addr = 0x100, mem_gnt = 1, mem_rvalid 2 cycles later with rdata 0xDEADBEEF -> ls_gnt for 1 cycle; ls_rvalid with ls_rdata = 0xDEADBEEF; stall high from request until the rvalid cycle.
- Contention: if_req and ls_req held, LS re-requests every cycle, memory 1-cycle latency, MAX_LS_STREAK = 4 -> grant order LS, LS, LS, LS, IF; streak_cnt returns to 0 after the IF grant.
- Back-to-back: store ls_mask = 4'b0100, ls_wdata = 0x00AB0000, addr 0x202; next request arrives in the same cycle as mem_rvalid -> new mem_req in that cycle; state stays WAIT; mem_mask = 4'b0100 on the store.
- Backpressure: mem_gnt = 0 for 3 cycles with if_req = 1 -> if_gnt = 0 and mem_req held with a stable address 0x40; grant taken on the 4th cycle.
- Timeout: TIMEOUT_CYCLES = 8, mem_rvalid never returned for an IF read -> if_rvalid = 1, if_err = 1 at the 8th WAIT cycle; state goes to IDLE; a later mem_rvalid produces no output.
- Reset mid-WAIT: rst_n = 0 while an LS load is outstanding, then released -> all outputs 0 during reset; no ls_rvalid after release; a new LS request is granted in the first post-reset cycle.
